// File: rtl/hs_pkg.sv
// Shared definitions for the word serializer family: FSM state encoding and default word width.
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } hs_state_e;

    localparam int HS_WORD_W = 8;

endpackage

// File: rtl/hs_bit_counter.sv
// Loadable down-counter with zero flag; saturates at zero, shared with the matching deserializer.
module hs_bit_counter
    import hs_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hs_word_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides and zero-bubble back-to-back words.
// Define HS_SER_PARITY_EN to append an even-parity bit after each word.
module hs_word_serializer
    import hs_pkg::*;
#(
    parameter int W         = HS_WORD_W,
    parameter int LSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic         out_data_o,
    input  logic         out_ready_i,
    output logic         busy_o
);

    localparam int CNT_W   = $clog2(W);
    localparam int OUT_IDX = (LSB_FIRST != 0) ? 0 : W - 1;

    hs_state_e    state_q;
    logic [W-1:0] shreg_q;
    logic         out_valid_q;
    logic         busy_q;
`ifdef HS_SER_PARITY_EN
    logic         par_q;
`endif

    logic         cnt_zero;
    logic         cnt_load;
    logic         cnt_dec;
    logic         in_hs;
    logic         out_hs;
    logic         end_beat;
    logic         cur_bit;
    logic [W-1:0] shreg_shifted;

    always_comb begin
        cur_bit = shreg_q[OUT_IDX];
        if (LSB_FIRST != 0) begin
            shreg_shifted = {1'b0, shreg_q[W-1:1]};
        end else begin
            shreg_shifted = {shreg_q[W-2:0], 1'b0};
        end
`ifdef HS_SER_PARITY_EN
        end_beat = (state_q == PARITY);
`else
        end_beat = (state_q == SHIFT) && cnt_zero;
`endif
        // Final beat of a word reopens the input in the same cycle the downstream takes it.
        in_ready_o = (state_q == IDLE) || (end_beat && out_ready_i);
        in_hs      = in_valid_i && in_ready_o;
        out_hs     = out_valid_q && out_ready_i;
        cnt_load   = in_hs;
        cnt_dec    = out_hs && (state_q == SHIFT) && !cnt_zero;
    end

    hs_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(W - 1)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef HS_SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        shreg_q     <= in_data_i;
                        state_q     <= SHIFT;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
`ifdef HS_SER_PARITY_EN
                        par_q       <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (out_hs) begin
`ifdef HS_SER_PARITY_EN
                        par_q <= par_q ^ cur_bit;
                        if (!cnt_zero) begin
                            shreg_q <= shreg_shifted;
                        end else begin
                            state_q <= PARITY;
                        end
`else
                        if (!cnt_zero) begin
                            shreg_q <= shreg_shifted;
                        end else if (in_hs) begin
                            shreg_q <= in_data_i;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
`endif
                    end
                end
`ifdef HS_SER_PARITY_EN
                PARITY: begin
                    if (out_hs) begin
                        if (in_hs) begin
                            shreg_q <= in_data_i;
                            par_q   <= 1'b0;
                            state_q <= SHIFT;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
`endif
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
`ifdef HS_SER_PARITY_EN
    assign out_data_o  = (state_q == PARITY) ? par_q : cur_bit;
`else
    assign out_data_o  = cur_bit;
`endif

endmodule

// File: tb/tb_hs_word_serializer.sv
// Scoreboard bench for hs_word_serializer: one MSB-first and one LSB-first instance on shared stimulus.
module tb_hs_word_serializer;
    import hs_pkg::*;

    localparam int W = HS_WORD_W;
`ifdef HS_SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready = 1'b1;

    logic in_ready_m, out_valid_m, out_data_m, busy_m;
    logic in_ready_l, out_valid_l, out_data_l, busy_l;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;
    int popped_m = 0;

    bit exp_m[$];
    bit exp_l[$];

    bit       bp_en = 1'b0;
    int       bp_k  = 0;
    bit [3:0] bp_pat = 4'b1001;

    logic stall_m = 1'b0, stall_l = 1'b0;
    logic sd_m = 1'b0, sd_l = 1'b0;

    hs_word_serializer #(
        .W         (W),
        .LSB_FIRST (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready_m),
        .out_valid_o (out_valid_m),
        .out_data_o  (out_data_m),
        .out_ready_i (out_ready),
        .busy_o      (busy_m)
    );

    hs_word_serializer #(
        .W         (W),
        .LSB_FIRST (1)
    ) dut_l (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready_l),
        .out_valid_o (out_valid_l),
        .out_data_o  (out_data_l),
        .out_ready_i (out_ready),
        .busy_o      (busy_l)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Backpressure pattern 1,0,0,1 repeating while enabled.
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            out_ready = bp_pat[bp_k % 4];
            bp_k++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_m = 1'b0;
            stall_l = 1'b0;
        end else begin
            if (stall_m) begin
                check("hold_valid_m", out_valid_m, 1);
                check("hold_data_m", out_data_m, sd_m);
            end
            if (stall_l) begin
                check("hold_valid_l", out_valid_l, 1);
                check("hold_data_l", out_data_l, sd_l);
            end
            if (out_valid_m && out_ready) begin
                if (exp_m.size() == 0) check("extra_bit_m", 1, 0);
                else check("bit_m", out_data_m, exp_m.pop_front());
                popped_m++;
            end
            if (out_valid_l && out_ready) begin
                if (exp_l.size() == 0) check("extra_bit_l", 1, 0);
                else check("bit_l", out_data_l, exp_l.pop_front());
            end
            stall_m = out_valid_m && !out_ready;
            stall_l = out_valid_l && !out_ready;
            sd_m    = out_data_m;
            sd_l    = out_data_l;
        end
    end

    // Leaves in_valid high on return so the caller can chain words back to back.
    task automatic send_word(input logic [W-1:0] d);
        int   n   = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = W - 1; i >= 0; i--) exp_m.push_back(d[i]);
        for (int i = 0; i < W; i++) exp_l.push_back(d[i]);
`ifdef HS_SER_PARITY_EN
        exp_m.push_back(^d);
        exp_l.push_back(^d);
`endif
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready_m;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        last_acc = cyc;
        check("latency_valid_m", out_valid_m, 1);
        check("latency_valid_l", out_valid_l, 1);
        check("busy_after_accept", busy_m, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_m.size() != 0 || exp_l.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
        check("idle_busy_m", busy_m, 0);
        check("idle_valid_m", out_valid_m, 0);
        check("idle_busy_l", busy_l, 0);
        check("idle_ready_m", in_ready_m, 1);
    endtask

    initial begin
        int a;
        int p0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        check("rst_in_ready", in_ready_m, 1);
        check("rst_out_valid", out_valid_m, 0);
        check("rst_out_data", out_data_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_out_valid_l", out_valid_l, 0);
        check("rst_busy_l", busy_l, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_word(8'hA5);
        in_valid = 1'b0;
        wait_drain();

        send_word(8'h3C);
        a  = last_acc;
        p0 = popped_m;
        send_word(8'hC3);
        in_valid = 1'b0;
        check("b2b_accept_spacing", last_acc - a, W + PB);
        repeat (W + PB) @(posedge clk);
        #1;
        check("b2b_no_gap", popped_m - p0, 2 * (W + PB));
        wait_drain();

        bp_en = 1'b1;
        send_word(8'hA5);
        in_valid = 1'b0;
        wait_drain();
        bp_en = 1'b0;

        send_word(8'hFF);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid_m", out_valid_m, 0);
        check("midrst_busy_m", busy_m, 0);
        check("midrst_valid_l", out_valid_l, 0);
        check("midrst_ready_m", in_ready_m, 1);
        exp_m.delete();
        exp_l.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_word(8'h01);
        in_valid = 1'b0;
        wait_drain();

        send_word(8'h07);
        in_valid = 1'b0;
        wait_drain();

        for (int k = 0; k < 8; k++) begin
            bp_en = (k % 3) == 1;
            send_word(W'($urandom));
        end
        in_valid = 1'b0;
        wait_drain();
        bp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
